// File: rtl/panel_pkg.sv
// panel_pkg: shared front-panel display types and segment patterns
package panel_pkg;
  typedef logic [3:0] bcd_t;
  typedef enum logic {ST_BLANK, ST_SHOW} scan_state_t;
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
endpackage

// File: rtl/bcd_display_scan_if.sv
// bcd_display_scan_if: timer digits in, active-low multiplexed display drive out
interface bcd_display_scan_if;
  logic        en;
  logic [15:0] digits;
  logic        colon;
  logic        blink;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  modport master(output en, digits, colon, blink, input seg, dp, an);
  modport slave(input en, digits, colon, blink, output seg, dp, an);
endinterface

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: BCD digit to active-low {g,f,e,d,c,b,a}, non-decimal codes show a dash
module bcd_to_seg
  import panel_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);
  // pure lookup, codes A..F fall through to the dash
  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/bcd_display_scan.sv
// bcd_display_scan: 4-digit multiplexed 7-segment scanner with colon, blanking and blink
module bcd_display_scan
  import panel_pkg::*;
#(
  parameter int SCAN_DIV    = 50,
  parameter int BLINK_SLOTS = 256,
  parameter bit LZB         = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  bcd_display_scan_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_SLOTS + 1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SLOTS - 1);
  logic [PW-1:0] pre;
  logic [1:0]    idx;
  scan_state_t   state;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [15:0]   shadow;
  logic          slot_end;
  logic          show;
  logic          dark;
  bcd_t          cur;
  logic [6:0]    cur_seg;
  assign slot_end = bus.en && pre == PRE_LAST;
  assign show     = bus.en && state == ST_SHOW;
  assign cur      = shadow[{idx, 2'b00} +: 4];
  assign dark     = (bus.blink && !blink_phase) || (LZB && idx == 2'd3 && shadow[15:12] == 4'd0);
  bcd_to_seg u_dec (.bcd(cur), .seg(cur_seg));
  // prescaler, slot FSM and frame-start shadow capture; all frozen while en is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre    <= '0;
      idx    <= '0;
      state  <= ST_BLANK;
      shadow <= '0;
    end else if (bus.en) begin
      pre   <= slot_end ? '0 : pre + 1'b1;
      idx   <= idx + {1'b0, slot_end};
      state <= slot_end ? ST_BLANK : ST_SHOW;
      if (state == ST_BLANK && idx == 2'd0) shadow <= bus.digits;
    end
  end
  // blink half-period counter in slots; idle at phase 1 when blink is off
  always_ff @(posedge clk) begin
    if (!rst_n || !bus.blink) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (slot_end) begin
      blink_cnt   <= blink_cnt == BLINK_LAST ? '0 : blink_cnt + 1'b1;
      blink_phase <= blink_cnt == BLINK_LAST ? ~blink_phase : blink_phase;
    end
  end
  // registered drive: anodes only in SHOW and not dark, colon dot on digit 2
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.seg <= SEG_OFF;
      bus.dp  <= 1'b1;
      bus.an  <= 4'hF;
    end else begin
      bus.an  <= show && !dark ? ~(4'b0001 << idx) : 4'hF;
      bus.seg <= show ? cur_seg : SEG_OFF;
      bus.dp  <= !(show && idx == 2'd2 && bus.colon);
    end
  end
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: directed checks of scan order, shadowing, blanking, colon, blink, en and reset
module tb_bcd_display_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  bcd_display_scan_if bus();
  bcd_display_scan #(.SCAN_DIV(4), .BLINK_SLOTS(2), .LZB(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic slot(input string tag, input int s, input logic lit, input logic [6:0] sg, input logic dpv);
    logic [3:0] a;
    a = lit ? ~(4'b0001 << s) : 4'hF;
    tick;
    chk({tag, " blank an"}, 16'(bus.an), 16'hF);
    chk({tag, " blank dp"}, 16'(bus.dp), 16'h1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk({tag, " an"}, 16'(bus.an), 16'(a));
      if (lit) chk({tag, " seg"}, 16'(bus.seg), 16'(sg));
      chk({tag, " dp"}, 16'(bus.dp), 16'(dpv));
    end
  endtask
  initial begin
    bus.en = 1'b0;
    bus.digits = 16'h0000;
    bus.colon = 1'b0;
    bus.blink = 1'b0;
    tick;
    tick;
    chk("rst an", 16'(bus.an), 16'hF);
    chk("rst seg", 16'(bus.seg), 16'h7F);
    chk("rst dp", 16'(bus.dp), 16'h1);
    rst_n = 1'b1;
    bus.en = 1'b1;
    bus.digits = 16'h1234;
    slot("t1 d0", 0, 1'b1, 7'h19, 1'b1);
    slot("t1 d1", 1, 1'b1, 7'h30, 1'b1);
    bus.digits = 16'h0559;
    slot("t2 old d2", 2, 1'b1, 7'h24, 1'b1);
    slot("t2 old d3", 3, 1'b1, 7'h79, 1'b1);
    slot("t2 d0", 0, 1'b1, 7'h10, 1'b1);
    slot("t2 d1", 1, 1'b1, 7'h12, 1'b1);
    slot("t2 d2", 2, 1'b1, 7'h12, 1'b1);
    slot("t2 d3 lzb", 3, 1'b0, 7'h7F, 1'b1);
    bus.digits = 16'h00AF;
    bus.colon = 1'b1;
    slot("t3 d0 dash", 0, 1'b1, 7'h3F, 1'b1);
    slot("t3 d1 dash", 1, 1'b1, 7'h3F, 1'b1);
    slot("t3 d2 colon", 2, 1'b1, 7'h40, 1'b0);
    slot("t3 d3 lzb", 3, 1'b0, 7'h7F, 1'b1);
    bus.colon = 1'b0;
    bus.digits = 16'h1234;
    bus.blink = 1'b1;
    for (int f = 0; f < 2; f++) begin
      slot("t4 d0 on", 0, 1'b1, 7'h19, 1'b1);
      slot("t4 d1 on", 1, 1'b1, 7'h30, 1'b1);
      slot("t4 d2 off", 2, 1'b0, 7'h7F, 1'b1);
      slot("t4 d3 off", 3, 1'b0, 7'h7F, 1'b1);
    end
    bus.blink = 1'b0;
    slot("t5 d0", 0, 1'b1, 7'h19, 1'b1);
    tick;
    chk("t5 d1 blank an", 16'(bus.an), 16'hF);
    tick;
    chk("t5 d1 pre an", 16'(bus.an), 16'hD);
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("t5 off an", 16'(bus.an), 16'hF);
      chk("t5 off seg", 16'(bus.seg), 16'h7F);
      chk("t5 off dp", 16'(bus.dp), 16'h1);
    end
    bus.en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("t5 resume an", 16'(bus.an), 16'hD);
      chk("t5 resume seg", 16'(bus.seg), 16'h30);
    end
    slot("t5 d2", 2, 1'b1, 7'h24, 1'b1);
    slot("t5 d3", 3, 1'b1, 7'h79, 1'b1);
    slot("t6 d0", 0, 1'b1, 7'h19, 1'b1);
    tick;
    tick;
    rst_n = 1'b0;
    tick;
    chk("t6 rst an", 16'(bus.an), 16'hF);
    chk("t6 rst seg", 16'(bus.seg), 16'h7F);
    chk("t6 rst dp", 16'(bus.dp), 16'h1);
    rst_n = 1'b1;
    slot("t6 first d0", 0, 1'b1, 7'h19, 1'b1);
    slot("t6 d1", 1, 1'b1, 7'h30, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
